// File: rtl/bytes_to_sram_if.sv
// Bus bundle for bytes_to_sram: upstream byte-command port plus the SRAM pin side.
// The slave modport is the controller; the master modport is the environment around it.
interface bytes_to_sram_if #(
    parameter int ADDR_WIDTH = 17
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [7:0]            mem_wr_data;
    logic [7:0]            mem_rd_data;
    logic                  mem_rd_data_valid;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [7:0]            sram_dq_out;
    logic                  sram_dq_oe;
    logic [7:0]            sram_dq_in;
    logic                  sram_ce_n;
    logic                  sram_oe_n;
    logic                  sram_we_n;
    logic                  overflow;

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wr_data, sram_dq_in,
        output mem_rd_data, mem_rd_data_valid, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, overflow
    );

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wr_data, sram_dq_in,
        input  mem_rd_data, mem_rd_data_valid, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, overflow
    );
endinterface

// File: rtl/bytes_to_sram.sv
// Byte-command to asynchronous SRAM controller: a command FIFO with no backpressure
// feeding a SETUP/ACCESS/HOLD strobe sequencer whose SRAM outputs are all registered.
module bytes_to_sram #(
    parameter int ADDR_WIDTH    = 17,
    parameter int FIFO_DEPTH    = 8,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    bytes_to_sram_if.slave  bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [PTR_W-1:0]      wptr_q, rptr_q, wptr_d, rptr_d;
    logic [ENTRY_W-1:0]    fifo_q [FIFO_DEPTH];
    logic                  overflow_q;
    logic                  op_rd_q;
    logic [ADDR_WIDTH-1:0] sram_addr_q;
    logic [7:0]            sram_dq_out_q;
    logic                  sram_dq_oe_q;
    logic                  sram_ce_n_q, sram_oe_n_q, sram_we_n_q;
    logic [7:0]            rd_data_q;
    logic                  rd_valid_q;

    logic                  fifo_empty, fifo_full, push_req, push, pop;
    logic [ENTRY_W-1:0]    head;
    logic                  head_rd;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [7:0]            head_data;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = ((wptr_q ^ rptr_q) == {1'b1, {(PTR_W-1){1'b0}}});
    assign pop        = !fifo_empty && ((state_q == IDLE) || (state_q == HOLD));
    assign push_req   = !reset && (bus.mem_rd || bus.mem_wr);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign push       = push_req && (!fifo_full || pop);
    assign wptr_d     = wptr_q + PTR_W'(push);
    assign rptr_d     = rptr_q + PTR_W'(pop);

    assign head      = fifo_q[rptr_q[PTR_W-2:0]];
    assign head_rd   = head[ENTRY_W-1];
    assign head_addr = head[8 +: ADDR_WIDTH];
    assign head_data = head[7:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q[PTR_W-2:0]] <= {bus.mem_rd, bus.mem_addr, bus.mem_wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_rd_q       <= 1'b0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_ce_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
            sram_we_n_q   <= 1'b1;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE, HOLD: begin
                    if (pop) begin
                        state_q      <= SETUP;
                        op_rd_q      <= head_rd;
                        sram_addr_q  <= head_addr;
                        sram_ce_n_q  <= 1'b0;
                        sram_oe_n_q  <= !head_rd;
                        sram_we_n_q  <= 1'b1;
                        sram_dq_oe_q <= !head_rd;
                        if (!head_rd) begin
                            sram_dq_out_q <= head_data;
                        end
                    end else begin
                        state_q      <= IDLE;
                        sram_ce_n_q  <= 1'b1;
                        sram_oe_n_q  <= 1'b1;
                        sram_we_n_q  <= 1'b1;
                        sram_dq_oe_q <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q     <= ACCESS;
                    cnt_q       <= 4'(ACCESS_CYCLES - 1);
                    sram_we_n_q <= op_rd_q;
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= HOLD;
                        sram_we_n_q <= 1'b1;
                        sram_oe_n_q <= 1'b1;
                        if (op_rd_q) begin
                            rd_data_q  <= bus.sram_dq_in;
                            rd_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sram_addr         = sram_addr_q;
    assign bus.sram_dq_out       = sram_dq_out_q;
    assign bus.sram_dq_oe        = sram_dq_oe_q;
    assign bus.sram_ce_n         = sram_ce_n_q;
    assign bus.sram_oe_n         = sram_oe_n_q;
    assign bus.sram_we_n         = sram_we_n_q;
    assign bus.mem_rd_data       = rd_data_q;
    assign bus.mem_rd_data_valid = rd_valid_q;
    assign bus.overflow          = overflow_q;
endmodule

// File: doc/bytes_to_sram.md
BYTES_TO_SRAM -- requirements
Module: bytes_to_sram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17: SRAM byte-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 4: command FIFO entries.
REQ-003 SHALL have parameter ACCESS_CYCLES, default 3, range 1-15: cycles the strobe is held active per access.
REQ-004 SHALL have clk input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have reset input, 1 bit: synchronous, active-high.
REQ-006 SHALL have mem_addr input, ADDR_WIDTH bits: byte address of the upstream byte command.
REQ-007 SHALL have mem_rd input, 1 bit: 1-cycle read command pulse.
REQ-008 SHALL have mem_wr input, 1 bit: 1-cycle write command pulse.
REQ-009 SHALL have mem_wr_data input, 8 bits: write byte.
REQ-010 SHALL have mem_rd_data output, 8 bits: read byte.
REQ-011 SHALL have mem_rd_data_valid output, 1 bit: 1-cycle pulse qualifying mem_rd_data.
REQ-012 SHALL have sram_addr output, ADDR_WIDTH bits: SRAM address.
REQ-013 SHALL have sram_dq_out output, 8 bits: SRAM write data.
REQ-014 SHALL have sram_dq_oe output, 1 bit: 1 drives sram_dq_out onto the pins.
REQ-015 SHALL have sram_dq_in input, 8 bits: SRAM read data.
REQ-016 SHALL have sram_ce_n, sram_oe_n and sram_we_n outputs, 1 bit each: active-low chip enable, output enable and write enable.
REQ-017 SHALL have overflow output, 1 bit: sticky flag set when a command is dropped.

Function
REQ-018 SHALL accept one command per cycle with no backpressure, because the upstream issues a byte command on every cycle for 4 consecutive cycles.
REQ-019 SHALL push {is_read, addr, wr_data} into the FIFO at the clock edge ending the cycle in which mem_rd or mem_wr is high.
REQ-020 SHALL accept only the read when mem_rd and mem_wr are both high in the same cycle.
REQ-021 SHALL drop a command that arrives when the FIFO is full, set overflow, and leave FIFO contents unchanged.
REQ-022 SHALL use pointers one bit wider than log2(FIFO_DEPTH) that wrap modulo 2*FIFO_DEPTH; full when the pointers differ only in the MSB, empty when they are equal.
REQ-023 SHALL, when the FIFO is full and a push coincides with a pop, accept the push and not set overflow.
REQ-024 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> HOLD with these transitions:
  - IDLE: when the FIFO is non-empty, pop one entry into the operation registers and go to SETUP.
  - SETUP: one cycle, then go to ACCESS.
  - ACCESS: exactly ACCESS_CYCLES cycles, counted by a 4-bit down-counter, then go to HOLD.
  - HOLD: one cycle; if the FIFO is non-empty, pop and go to SETUP, otherwise go to IDLE.
REQ-025 SHALL drive all SRAM outputs from registers.
REQ-026 SHALL, in SETUP, ACCESS and HOLD, hold sram_addr at the latched address and sram_ce_n at 0.
REQ-027 SHALL, in IDLE, drive sram_ce_n = sram_oe_n = sram_we_n = 1 and sram_dq_oe = 0.
REQ-028 SHALL drive a write as follows:
  - SETUP through HOLD: sram_dq_out = latched data, sram_dq_oe = 1, sram_oe_n = 1.
  - sram_we_n = 0 only during ACCESS.
REQ-029 SHALL drive a read as follows:
  - sram_dq_oe = 0 and sram_we_n = 1 throughout.
  - sram_oe_n = 0 during SETUP and ACCESS, 1 in HOLD.
REQ-030 SHALL capture sram_dq_in into mem_rd_data at the edge ending the last ACCESS cycle.
REQ-031 SHALL pulse mem_rd_data_valid for exactly the one HOLD cycle of that read.
REQ-032 SHALL hold mem_rd_data stable until the next read capture.
REQ-033 SHALL complete commands strictly in arrival order; read data returns in order.
REQ-034 SHALL take ACCESS_CYCLES+2 cycles per access.
REQ-035 SHALL, for a command accepted at the edge ending cycle T into an empty FIFO with FSM IDLE, place SETUP in cycle T+2 and, for a read, mem_rd_data_valid in cycle T+3+ACCESS_CYCLES.
REQ-036 SHALL keep mem_rd_data_valid at 0 for writes.

Reset
REQ-037 SHALL, on reset high at a clock edge, set on the following cycle:
  - FSM = IDLE, FIFO empty.
  - sram_ce_n = sram_oe_n = sram_we_n = 1, sram_dq_oe = 0.
  - mem_rd_data_valid = 0, overflow = 0.
  - mem_rd_data = 0, sram_addr = 0, sram_dq_out = 0.
REQ-038 SHALL, on reset mid-access, abort the access: strobes deassert on the next cycle, no valid pulse is produced, and queued commands are discarded.
REQ-039 SHALL ignore commands presented in a cycle where reset is high.
REQ-040 SHALL clear overflow only by reset.

Verification
REQ-041 SHALL cover: single write, ACCESS_CYCLES=3, addr 0x00010, data 0xA5 -> SETUP in T+2; sram_we_n low for exactly 3 cycles; sram_dq_oe high for 5 cycles; mem_rd_data_valid never asserted.
REQ-042 SHALL cover: SRAM model preloaded with 0x5C at addr 0x00123, single read -> mem_rd_data = 0x5C, mem_rd_data_valid high in T+6 only.
REQ-043 SHALL cover: 4 consecutive-cycle writes of 0x11,0x22,0x33,0x44 to addrs 0x40-0x43, then 4 consecutive reads of the same addrs -> read bytes return in order 0x11,0x22,0x33,0x44; each access takes 5 cycles; overflow = 0.
REQ-044 SHALL cover: FIFO_DEPTH=4, 6 consecutive-cycle writes with FSM IDLE -> first 4 plus the one accepted on the first pop (push coincident with pop, REQ-023) are written; the 6th is dropped; overflow = 1 and stays 1.
REQ-045 SHALL cover: mem_rd and mem_wr high together -> exactly one read performed; no SRAM write strobe.
REQ-046 SHALL cover: reset asserted in the 2nd ACCESS cycle of a read with 2 commands queued -> next cycle all strobes high; no mem_rd_data_valid; no further SRAM activity.
